// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared constants for the modulo up/down counter family.
//   CTRL_*  : encodings of the 2-bit control input
//   MODE_*  : boundary handling selected by sat_mode
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_INC  = 2'b01;
    localparam logic [1:0] CTRL_DEC  = 2'b10;
    localparam logic [1:0] CTRL_CLR  = 2'b11;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Step direction fed to the arithmetic unit.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mod_step_alu.sv
// ----------------------------------------------------------------------------
// mod_step_alu
// Combinational next-count computation for one increment or decrement by s
// within the range 0..MODULO-1, wrapping or saturating at the boundaries.
// Ports:
//   i_count    current count (must be < MODULO)
//   i_step     effective step (already clamped to <= MODULO-1)
//   i_dir      DIR_UP / DIR_DOWN
//   i_sat_mode MODE_WRAP / MODE_SAT
//   o_next     next count
//   o_ovf      upper boundary crossed by this step
//   o_unf      lower boundary crossed by this step
// ----------------------------------------------------------------------------
module mod_step_alu
    import counter_pkg::*;
#(
    parameter int W      = 8,
    parameter int MODULO = 256
) (
    input  logic [W-1:0] i_count,
    input  logic [W-1:0] i_step,
    input  logic         i_dir,
    input  logic         i_sat_mode,
    output logic [W-1:0] o_next,
    output logic         o_ovf,
    output logic         o_unf
);

    // MODULO may equal 2^W, so the modulus and all sums carry one extra bit.
    localparam logic [W:0] LP_MOD = (W+1)'(MODULO);
    localparam logic [W:0] LP_MAX = LP_MOD - 1'b1;

    logic [W:0] w_cnt;
    logic [W:0] w_stp;
    logic [W:0] w_sum;
    logic [W:0] w_wrap_up;
    logic [W:0] w_diff;
    logic [W:0] w_wrap_dn;

    assign w_cnt     = {1'b0, i_count};
    assign w_stp     = {1'b0, i_step};
    assign w_sum     = w_cnt + w_stp;
    // Both operands are < MODULO, so one subtraction of MODULO suffices.
    assign w_wrap_up = w_sum - LP_MOD;
    assign w_diff    = w_cnt - w_stp;
    assign w_wrap_dn = w_cnt + LP_MOD - w_stp;

    always_comb begin
        o_next = i_count;
        o_ovf  = 1'b0;
        o_unf  = 1'b0;
        if (i_dir == DIR_UP) begin
            if (w_sum <= LP_MAX) begin
                o_next = w_sum[W-1:0];
            end else begin
                o_ovf  = 1'b1;
                o_next = (i_sat_mode == MODE_SAT) ? LP_MAX[W-1:0] : w_wrap_up[W-1:0];
            end
        end else begin
            if (w_stp <= w_cnt) begin
                o_next = w_diff[W-1:0];
            end else begin
                o_unf  = 1'b1;
                o_next = (i_sat_mode == MODE_SAT) ? '0 : w_wrap_dn[W-1:0];
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// ----------------------------------------------------------------------------
// mod_updown_counter
// Modulo-MODULO up/down counter with programmable step, synchronous parallel
// load, wrap/saturate boundary mode, overflow/underflow pulses and boundary
// flags. Priority each cycle: rst > load > control.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   control      00 hold, 01 inc, 10 dec, 11 clear
//   load/load_val parallel load (clamped to MODULO-1)
//   step         inc/dec amount (clamped to MODULO-1)
//   sat_mode     0 wrap, 1 saturate
//   count        registered count
//   at_max/at_min combinational boundary flags
//   ovf/unf      registered one-cycle boundary-crossing pulses
// Optional build macro MOD_COUNTER_MATCH_EN adds:
//   match_val    compare value
//   match        registered pulse when count changes to match_val
// ----------------------------------------------------------------------------
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int W      = 8,
    parameter int MODULO = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   control,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] step,
    input  logic         sat_mode,
`ifdef MOD_COUNTER_MATCH_EN
    input  logic [W-1:0] match_val,
    output logic         match,
`endif
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         at_min,
    output logic         ovf,
    output logic         unf
);

    generate
        if (W < 2 || MODULO < 2 || MODULO > (2 ** W)) begin : g_bad_param
            $error("mod_updown_counter: illegal W/MODULO combination");
        end
    endgenerate

    localparam logic [W:0]   LP_MOD   = (W+1)'(MODULO);
    localparam logic [W:0]   LP_MAX   = LP_MOD - 1'b1;
    localparam logic [W-1:0] LP_MAX_W = LP_MAX[W-1:0];

    logic [W-1:0] r_count;
    logic         r_ovf;
    logic         r_unf;

    logic [W-1:0] w_step_eff;
    logic [W-1:0] w_load_eff;
    logic [W-1:0] w_alu_next;
    logic         w_alu_ovf;
    logic         w_alu_unf;
    logic [W-1:0] w_count_nxt;
    logic         w_ovf_nxt;
    logic         w_unf_nxt;

    // Out-of-range step/load values saturate at the top of the range.
    assign w_step_eff = ({1'b0, step}     < LP_MOD) ? step     : LP_MAX_W;
    assign w_load_eff = ({1'b0, load_val} <= LP_MAX) ? load_val : LP_MAX_W;

    mod_step_alu #(
        .W      (W),
        .MODULO (MODULO)
    ) u_alu (
        .i_count    (r_count),
        .i_step     (w_step_eff),
        .i_dir      ((control == CTRL_DEC) ? DIR_DOWN : DIR_UP),
        .i_sat_mode (sat_mode),
        .o_next     (w_alu_next),
        .o_ovf      (w_alu_ovf),
        .o_unf      (w_alu_unf)
    );

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        if (load) begin
            w_count_nxt = w_load_eff;
        end else begin
            case (control)
                CTRL_INC: begin
                    w_count_nxt = w_alu_next;
                    w_ovf_nxt   = w_alu_ovf;
                end
                CTRL_DEC: begin
                    w_count_nxt = w_alu_next;
                    w_unf_nxt   = w_alu_unf;
                end
                CTRL_CLR: w_count_nxt = '0;
                default:  w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

`ifdef MOD_COUNTER_MATCH_EN
    logic r_match;

    // Pulse only on a change into match_val, so holding there stays quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match <= 1'b0;
        end else begin
            r_match <= (w_count_nxt != r_count) && (w_count_nxt == match_val);
        end
    end

    assign match = r_match;
`endif

    assign count  = r_count;
    assign ovf    = r_ovf;
    assign unf    = r_unf;
    assign at_max = (r_count == LP_MAX_W);
    assign at_min = (r_count == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

    localparam int W      = 4;
    localparam int MODULO = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   control;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] step;
    logic         sat_mode;
    logic [W-1:0] count;
    logic         at_max, at_min, ovf, unf;
`ifdef MOD_COUNTER_MATCH_EN
    logic [W-1:0] match_val;
    logic         match;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.W(W), .MODULO(MODULO)) dut (
        .clk      (clk),
        .rst      (rst),
        .control  (control),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .sat_mode (sat_mode),
`ifdef MOD_COUNTER_MATCH_EN
        .match_val(match_val),
        .match    (match),
`endif
        .count    (count),
        .at_max   (at_max),
        .at_min   (at_min),
        .ovf      (ovf),
        .unf      (unf)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check count plus both event pulses in one go.
    task automatic chk_cnt(input string tag, input int c, input bit o, input bit u);
        chk({tag, ".count"}, 8'(count), 8'(c));
        chk({tag, ".ovf"},   8'(ovf),   8'(o));
        chk({tag, ".unf"},   8'(unf),   8'(u));
    endtask

    task automatic drive(input bit r, input bit ld, input int lv,
                         input logic [1:0] ctl, input int st, input bit sm);
        rst      = r;
        load     = ld;
        load_val = W'(lv);
        control  = ctl;
        step     = W'(st);
        sat_mode = sm;
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MOD_COUNTER_MATCH_EN
        match_val = 4'd5;
`endif
        drive(1, 0, 0, 2'b00, 0, 0);
        tick();
        chk_cnt("reset", 0, 0, 0);
        chk("reset.at_min", 8'(at_min), 8'd1);
        chk("reset.at_max", 8'(at_max), 8'd0);

        // wrap inc 8+3 -> 1 with ovf
        drive(0, 1, 8, 2'b00, 0, 0); tick();
        chk_cnt("load8", 8, 0, 0);
        drive(0, 0, 0, 2'b01, 3, 0); tick();
        chk_cnt("wrap_inc", 1, 1, 0);
        chk("wrap_inc.at_max", 8'(at_max), 8'd0);
        drive(0, 0, 0, 2'b00, 3, 0); tick();
        chk_cnt("hold_after_ovf", 1, 0, 0);

        // saturate dec 2-5 -> 0 with unf, twice
        drive(0, 1, 2, 2'b00, 0, 1); tick();
        drive(0, 0, 0, 2'b10, 5, 1); tick();
        chk_cnt("sat_dec1", 0, 0, 1);
        chk("sat_dec1.at_min", 8'(at_min), 8'd1);
        tick();
        chk_cnt("sat_dec2", 0, 0, 1);
        drive(0, 0, 0, 2'b00, 5, 1); tick();
        chk_cnt("hold_after_unf", 0, 0, 0);

        // load wins over inc and clamps 15 -> 9
        drive(0, 1, 15, 2'b01, 1, 0); tick();
        chk_cnt("load_clamp", 9, 0, 0);
        chk("load_clamp.at_max", 8'(at_max), 8'd1);

        // saturate clip at max pulses ovf, then wrap 9+1 -> 0
        drive(0, 0, 0, 2'b01, 1, 1); tick();
        chk_cnt("sat_clip", 9, 1, 0);
        drive(0, 0, 0, 2'b01, 1, 0); tick();
        chk_cnt("wrap_9to0", 0, 1, 0);

        // reset beats load mid-stream
        drive(0, 1, 6, 2'b00, 0, 0); tick();
        chk_cnt("load6", 6, 0, 0);
        drive(1, 1, 3, 2'b01, 1, 0); tick();
        chk_cnt("rst_wins", 0, 0, 0);

        // clear
        drive(0, 1, 5, 2'b00, 0, 0); tick();
        drive(0, 0, 7, 2'b11, 4, 1); tick();
        chk_cnt("clear", 0, 0, 0);

        // step 0 then oversized step 12 -> s=9
        drive(0, 0, 0, 2'b01, 0, 0); tick();
        chk_cnt("step0", 0, 0, 0);
        drive(0, 0, 0, 2'b01, 12, 0); tick();
        chk_cnt("step12", 9, 0, 0);

        // wrap dec 3-5 -> 8 with unf, then plain dec 8-2 -> 6
        drive(0, 1, 3, 2'b00, 0, 0); tick();
        drive(0, 0, 0, 2'b10, 5, 0); tick();
        chk_cnt("wrap_dec", 8, 0, 1);
        drive(0, 0, 0, 2'b10, 2, 0); tick();
        chk_cnt("plain_dec", 6, 0, 0);

`ifdef MOD_COUNTER_MATCH_EN
        drive(0, 1, 3, 2'b00, 0, 0); tick();
        chk("match.load3", 8'(match), 8'd0);
        drive(0, 0, 0, 2'b01, 1, 0); tick();
        chk("match.at4", 8'(match), 8'd0);
        tick();
        chk("match.at5", 8'(match), 8'd1);
        chk("match.count5", 8'(count), 8'd5);
        drive(0, 0, 0, 2'b00, 1, 0); tick();
        chk("match.hold1", 8'(match), 8'd0);
        tick();
        chk("match.hold2", 8'(match), 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised successor to the team's 2-bit-controlled up/down counter.
- Adds:
  - arbitrary modulus;
  - programmable step;
  - synchronous parallel load;
  - wrap or saturate boundary mode;
  - overflow/underflow event pulses;
  - boundary flags.
- Used for timers, score/position counters and frame/tile indices wherever a range other than 2^W is needed.

Parameters:
- W, 8, counter width in bits (W >= 2).
- MODULO, 256, number of count states; count range 0..MODULO-1. Legal range is 2 <= MODULO <= 2^W; values outside this range are an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- control  in  2  operation select: 00 hold, 01 increment, 10 decrement, 11 clear.
- load  in  1  parallel load request; overrides control.
- load_val  in  W  value for load.
- step  in  W  increment/decrement amount.
- sat_mode  in  1  boundary mode: 0 = wrap (modular), 1 = saturate.
- count  out  W  current count, registered.
- at_max  out  1  combinational, count == MODULO-1.
- at_min  out  1  combinational, count == 0.
- ovf  out  1  registered one-cycle pulse on upper-boundary crossing.
- unf  out  1  registered one-cycle pulse on lower-boundary crossing.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values: count=0, ovf=0, unf=0, hence at_min=1 and at_max=0.
- All updates occur on the rising edge of clk, with one-cycle latency from inputs to count/ovf/unf.
- Priority per cycle: rst > load > control.
- Step handling:
  - Effective step s = step when step < MODULO, otherwise MODULO-1. This clamping is applied before any arithmetic.
  - All arithmetic is done in W+1 bits, so there is no silent truncation.
- load:
  - count <= load_val if load_val <= MODULO-1, otherwise MODULO-1.
  - ovf=0, unf=0.
- control=00 (hold): count unchanged; ovf=0, unf=0.
- control=11 (clear): count <= 0; ovf=0, unf=0.
- control=01 (increment), with sum = count + s:
  - If sum <= MODULO-1: count <= sum, ovf=0.
  - Else, wrap mode: count <= sum - MODULO, ovf=1.
  - Else, saturate mode: count <= MODULO-1, ovf=1.
  - In saturate mode with count already at MODULO-1 and s>0, ovf pulses every such cycle (clip indication).
- control=10 (decrement):
  - If s <= count: count <= count - s, unf=0.
  - Else, wrap mode: count <= count + MODULO - s, unf=1.
  - Else, saturate mode: count <= 0, unf=1.
- s=0 with increment or decrement: count unchanged; ovf=0, unf=0.
- ovf and unf are never asserted in the same cycle.
- sat_mode is sampled every cycle; there is no stored mode state.
- rst asserted mid-operation wins unconditionally and clears the flags on the same edge.
- load_val, step and sat_mode are ignored whenever they do not apply to the selected operation.

Optional Feature:
- Macro: MOD_COUNTER_MATCH_EN.
- When defined, the block adds two ports:
  - input match_val [W];
  - output match [1], registered.
- match behaviour:
  - match=1 for exactly one cycle when the next count equals match_val and differs from the current count.
  - Any change of count qualifies: load, clear, increment or decrement.
  - Reset value of match is 0.
  - Holding at the match value does not re-pulse.
- When not defined, neither port nor any comparison logic exists.

Decomposition:
- Shared package counter_pkg holds:
  - control encodings CTRL_HOLD=2'b00, CTRL_INC=2'b01, CTRL_DEC=2'b10, CTRL_CLR=2'b11;
  - boundary-mode constants MODE_WRAP=1'b0, MODE_SAT=1'b1.
- One sub-module is natural: mod_step_alu.
  - Purely combinational.
  - Inputs: count, s, direction, sat_mode.
  - Outputs: next count, ovf, unf.
- The top level holds the registers, the priority mux and the optional match logic.

Test Plan:
- W=4, MODULO=10, wrap, count=8, inc step=3 -> count=1, ovf pulses 1 cycle, at_max=0.
- W=4, MODULO=10, saturate, count=2, dec step=5 -> count=0, unf=1, at_min=1; a second dec -> count stays 0, unf=1 again.
- load=1 with load_val=15 and control=01 in the same cycle, MODULO=10 -> count=9 (clamped, load wins), ovf=0, at_max=1.
- Counting mid-stream (count=6), assert rst together with load=1 and load_val=3 -> next cycle count=0, ovf=0, unf=0.
- step=0 inc, then step=12 inc from count=0 with MODULO=10 wrap -> first: count 0, no flags; second: s=9, count=9, ovf=0.
- MOD_COUNTER_MATCH_EN defined, match_val=5, inc step=1 from 3 then hold -> match high only on the edge where count becomes 5, low while holding.
